// File: rtl/err_metric_pkg.sv
// Shared state type and width helpers for the approximate-multiplier error accumulator.
// No logic here; accumulator widths are exact so nothing overflows at the maximum sample count.
package err_metric_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int PW        = 2 * DEF_WIDTH;
  localparam int ERR_W     = PW + 1;
  localparam int SQ_W      = 2 * PW;

  // Signed error sum: one sign bit over the product width, plus one bit per doubling of samples.
  function automatic int sum_err_w(input int pw, input int cnt_w);
    return pw + 1 + cnt_w;
  endfunction

  function automatic int sum_abs_w(input int pw, input int cnt_w);
    return pw + cnt_w;
  endfunction

  function automatic int sum_sq_w(input int pw, input int cnt_w);
    return 2 * pw + cnt_w;
  endfunction

endpackage

// File: rtl/err_calc_stage.sv
// Combinational exact product, signed error, magnitude and square for one operand pair.
// Zero latency, no handshake; the caller registers the outputs.
module err_calc_stage
  import err_metric_pkg::*;
#(
  parameter int W = DEF_WIDTH,
  parameter int P = PW,
  parameter int E = ERR_W,
  parameter int S = SQ_W
) (
  input  logic [W-1:0]        i_a,
  input  logic [W-1:0]        i_b,
  input  logic [P-1:0]        i_approx,
  output logic signed [E-1:0] o_err,
  output logic [P-1:0]        o_abs,
  output logic [S-1:0]        o_sq
);

  logic [P-1:0] w_exact;

  assign w_exact = P'(i_a) * P'(i_b);
  assign o_err   = $signed({1'b0, i_approx}) - $signed({1'b0, w_exact});
  // |err| never exceeds 2^P-1, so the sign bit can be dropped after negation.
  assign o_abs   = o_err[E-1] ? P'(-o_err) : P'(o_err);
  assign o_sq    = S'(o_abs) * S'(o_abs);

endmodule

// File: rtl/approx_err_accum.sv
// Streams (a, b, approx) samples and accumulates bias, abs, squared, max and nonzero-count error metrics.
// Accept-to-output latency 3 cycles; in_ready high only in RUN, no backpressure inside the pipeline.
module approx_err_accum
  import err_metric_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [CNT_W-1:0]                              num_samples,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [WIDTH-1:0]                              in_a,
  input  logic [WIDTH-1:0]                              in_b,
  input  logic [2*WIDTH-1:0]                            in_approx,
  output logic                                          busy,
  output logic                                          done,
  output logic signed [sum_err_w(2*WIDTH, CNT_W)-1:0]   sum_err,
  output logic [sum_abs_w(2*WIDTH, CNT_W)-1:0]          sum_abs_err,
  output logic [sum_sq_w(2*WIDTH, CNT_W)-1:0]           sum_sq_err,
  output logic [2*WIDTH-1:0]                            max_abs_err,
  output logic [CNT_W-1:0]                              err_count
);

  localparam int P  = 2 * WIDTH;
  localparam int E  = P + 1;
  localparam int S  = 2 * P;
  localparam int SE = sum_err_w(P, CNT_W);
  localparam int SA = sum_abs_w(P, CNT_W);
  localparam int SS = sum_sq_w(P, CNT_W);

  state_t r_state, w_state_nxt;

  logic [CNT_W-1:0]     r_num, r_accepted;
  logic                 w_accept, w_last, w_clear, w_pipe_empty;

  logic                 r_s1_vld;
  logic [WIDTH-1:0]     r_s1_a, r_s1_b;
  logic [P-1:0]         r_s1_approx;

  logic signed [E-1:0]  w_err;
  logic [P-1:0]         w_abs;
  logic [S-1:0]         w_sq;

  logic                 r_s2_vld, r_s3_vld;
  logic signed [E-1:0]  r_s2_err, r_s3_err;
  logic [P-1:0]         r_s2_abs, r_s3_abs;
  logic [S-1:0]         r_s2_sq, r_s3_sq;

  logic signed [SE-1:0] r_sum_err;
  logic [SA-1:0]        r_sum_abs;
  logic [SS-1:0]        r_sum_sq;
  logic [P-1:0]         r_max_abs;
  logic [CNT_W-1:0]     r_err_cnt;

  // Accept depends only on state, keeping in_ready free of any in_valid path.
  assign w_accept     = in_valid && (r_state == RUN);
  assign w_last       = (r_accepted == (r_num - CNT_W'(1)));
  assign w_pipe_empty = !(r_s1_vld || r_s2_vld || r_s3_vld);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        done = (r_state == DONE);
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (w_accept && w_last) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (w_pipe_empty) begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  err_calc_stage #(
    .W (WIDTH),
    .P (P),
    .E (E),
    .S (S)
  ) u_calc (
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .i_approx (r_s1_approx),
    .o_err    (w_err),
    .o_abs    (w_abs),
    .o_sq     (w_sq)
  );

  // S3 is a plain retiming register so the wide accumulator adds start from flops, not the multipliers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld    <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_approx <= '0;
      r_s2_vld    <= 1'b0;
      r_s2_err    <= '0;
      r_s2_abs    <= '0;
      r_s2_sq     <= '0;
      r_s3_vld    <= 1'b0;
      r_s3_err    <= '0;
      r_s3_abs    <= '0;
      r_s3_sq     <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_a      <= in_a;
        r_s1_b      <= in_b;
        r_s1_approx <= in_approx;
      end
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_err <= w_err;
        r_s2_abs <= w_abs;
        r_s2_sq  <= w_sq;
      end
      r_s3_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_s3_err <= r_s2_err;
        r_s3_abs <= r_s2_abs;
        r_s3_sq  <= r_s2_sq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_num      <= '0;
      r_accepted <= '0;
      r_sum_err  <= '0;
      r_sum_abs  <= '0;
      r_sum_sq   <= '0;
      r_max_abs  <= '0;
      r_err_cnt  <= '0;
    end else if (w_clear) begin
      r_num      <= num_samples;
      r_accepted <= '0;
      r_sum_err  <= '0;
      r_sum_abs  <= '0;
      r_sum_sq   <= '0;
      r_max_abs  <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_accepted <= r_accepted + CNT_W'(1);
      end
      if (r_s3_vld) begin
        r_sum_err <= r_sum_err + $signed({{(SE-E){r_s3_err[E-1]}}, r_s3_err});
        r_sum_abs <= r_sum_abs + SA'(r_s3_abs);
        r_sum_sq  <= r_sum_sq + SS'(r_s3_sq);
        if (r_s3_abs > r_max_abs) begin
          r_max_abs <= r_s3_abs;
        end
        if (r_s3_err != '0) begin
          r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign sum_err     = r_sum_err;
  assign sum_abs_err = r_sum_abs;
  assign sum_sq_err  = r_sum_sq;
  assign max_abs_err = r_max_abs;
  assign err_count   = r_err_cnt;

endmodule

// File: tb/tb_approx_err_accum.sv
// Randomized and directed bench for approx_err_accum against a plain-arithmetic metric model.
module tb_approx_err_accum;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [CNT_W-1:0]   num_samples;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a, in_b;
  logic [2*WIDTH-1:0] in_approx;
  logic               busy, done;
  logic signed [32:0] sum_err;
  logic [31:0]        sum_abs_err;
  logic [47:0]        sum_sq_err;
  logic [15:0]        max_abs_err;
  logic [CNT_W-1:0]   err_count;

  approx_err_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_approx   (in_approx),
    .busy        (busy),
    .done        (done),
    .sum_err     (sum_err),
    .sum_abs_err (sum_abs_err),
    .sum_sq_err  (sum_sq_err),
    .max_abs_err (max_abs_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  int     n_acc;
  longint m_se, m_sa, m_sq, m_max, m_cnt;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_se = 0; m_sa = 0; m_sq = 0; m_max = 0; m_cnt = 0;
    n_acc = 0;
  endtask

  task automatic model_add(input int a, input int b, input int ap);
    longint e, ae;
    e  = longint'(ap) - longint'(a) * longint'(b);
    ae = (e < 0) ? -e : e;
    m_se += e;
    m_sa += ae;
    m_sq += ae * ae;
    if (ae > m_max) m_max = ae;
    if (e != 0) m_cnt++;
    n_acc++;
  endtask

  task automatic check_results(input string tag);
    check({tag, "_sum_err"}, sum_err, m_se);
    check({tag, "_sum_abs"}, longint'(sum_abs_err), m_sa);
    check({tag, "_sum_sq"}, longint'(sum_sq_err), m_sq);
    check({tag, "_max_abs"}, longint'(max_abs_err), m_max);
    check({tag, "_err_cnt"}, longint'(err_count), m_cnt);
  endtask

  task automatic start_run(input int n);
    start       = 1'b1;
    num_samples = CNT_W'(n);
    model_clear();
    step();
    start = 1'b0;
  endtask

  // An accept happens at the next edge when in_ready is already high here.
  task automatic drive_sample(input int a, input int b, input int ap);
    in_a      = WIDTH'(a);
    in_b      = WIDTH'(b);
    in_approx = 16'(ap);
    in_valid  = 1'b1;
    if (in_ready) model_add(a, b, ap);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drive_rand();
    int a, b, ex, ap, mode;
    a    = int'($urandom_range(0, 255));
    b    = int'($urandom_range(0, 255));
    ex   = a * b;
    mode = int'($urandom_range(0, 2));
    if (mode == 0) ap = ex;
    else if (mode == 1) ap = int'($urandom_range(0, 65535));
    else begin
      ap = ex + int'($urandom_range(0, 64)) - 32;
      if (ap < 0) ap = 0;
      if (ap > 65535) ap = 65535;
    end
    drive_sample(a, b, ap);
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (!done && i < 100) begin
      step();
      i++;
    end
    check({tag, "_done"}, done, 1);
  endtask

  task automatic random_run(input int n);
    int guard;
    guard = 0;
    start_run(n);
    while (n_acc < n && guard < 500) begin
      guard++;
      if ($urandom_range(0, 3) == 0) step();
      else drive_rand();
    end
    check("rnd_accepts", n_acc, n);
    wait_done("rnd");
    check_results("rnd");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[7];
    rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_approx = '0;
    model_clear();
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check_results("rst");
    rst = 1'b0;
    step();

    // Exact products only: every metric stays zero.
    start_run(3);
    drive_sample(3, 5, 15);
    drive_sample(0, 200, 0);
    drive_sample(255, 255, 65025);
    wait_done("exact");
    check("exact_busy", busy, 0);
    check_results("exact");

    // Mixed errors with cycle-exact latency checks.
    start_run(2);
    drive_sample(255, 255, 60000);
    drive_sample(10, 10, 101);
    step();
    check("lat_k2_max", longint'(max_abs_err), 0);
    step();
    check("lat_k3_max", longint'(max_abs_err), 5025);
    check("lat_k3_sum", sum_err, -5025);
    check("lat_k3_cnt", longint'(err_count), 1);
    step();
    check("mixed_sum_err_c", sum_err, -5024);
    check("mixed_sum_abs_c", longint'(sum_abs_err), 5026);
    check("mixed_sum_sq_c", longint'(sum_sq_err), 25250626);
    check("mixed_done_early", done, 0);
    step();
    check("mixed_done", done, 1);
    check("mixed_busy", busy, 0);
    check_results("mixed");

    // Gapped valid; the fifth offered sample must be refused.
    pat = '{1, 0, 1, 1, 0, 1, 1};
    start_run(4);
    check("bp_ready_run", in_ready, 1);
    foreach (pat[i]) begin
      if (pat[i] == 1) begin
        drive_rand();
        if (n_acc == 4 && i == 5) check("bp_ready_drop", in_ready, 0);
      end else begin
        step();
      end
    end
    check("bp_accepts", n_acc, 4);
    wait_done("bp");
    check_results("bp");

    // Zero-length run.
    start_run(0);
    check("n0_done", done, 1);
    check("n0_in_ready", in_ready, 0);
    check("n0_busy", busy, 0);
    check_results("n0");

    // Start during RUN is ignored.
    start_run(3);
    drive_rand();
    start = 1'b1; num_samples = 16'd7;
    step();
    start = 1'b0;
    check("ign_busy", busy, 1);
    drive_rand();
    drive_rand();
    wait_done("ign");
    check("ign_accepts", n_acc, 3);
    check_results("ign");

    // Restart from DONE clears accumulators.
    start_run(1);
    check("rs_done_drop", done, 0);
    check("rs_cleared_abs", longint'(sum_abs_err), 0);
    check("rs_cleared_cnt", longint'(err_count), 0);
    drive_sample(2, 3, 7);
    wait_done("rs");
    check("rs_sum_err_c", sum_err, 1);
    check("rs_max_c", longint'(max_abs_err), 1);
    check("rs_cnt_c", longint'(err_count), 1);
    check_results("rs");

    // Reset after two of five accepts.
    start_run(5);
    drive_rand();
    drive_rand();
    rst = 1'b1;
    step();
    model_clear();
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_in_ready", in_ready, 0);
    check_results("mr");
    rst = 1'b0;
    step();
    start_run(1);
    drive_sample(100, 3, 290);
    wait_done("mr2");
    check_results("mr2");

    repeat (8) random_run(int'($urandom_range(1, 20)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
